stack_engine: RTL and testbench
===============================

# stack_engine

Sequencer for the PUSH/POP register-pair micro-operations of the 8-bit CPU. It sits directly upstream of the register file: it drives the file's read/write selectors, write data and extended increment/decrement ops on the SP pair, and moves bytes between a register pair and memory over a ready-handshaked byte bus. Control logic starts one operation per `start` pulse and waits for `done`.

## Interface
- `SP_INDEX`, 4'd8: register-file index of SP high byte; low byte at `SP_INDEX+1`; SP selector = {1'b1, SP_INDEX}.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin operation; sampled only in IDLE.
- `op` input 1: 0 = PUSH, 1 = POP; latched with `start`.
- `pair_sel` input 4: register-file index of pair high byte; latched with `start`.
- `rf_rdata` input 16: register-file read data for `rf_read_sel`.
- `rf_read_sel` output 5: register-file read selector.
- `rf_write_sel` output 5: register-file write selector.
- `rf_write_en` output 1: register-file write enable.
- `rf_wdata` output 16: register-file write data.
- `rf_ext_op` output 2: 00 none, 01 INC, 10 DCR, 11 INC2.
- `mem_addr` output 16: byte address.
- `mem_wdata` output 8: write byte.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: 1 = write, 0 = read; valid with `mem_req`.
- `mem_rdata` input 8: read byte, captured when `mem_ready` is high.
- `mem_ready` input 1: access completes at the edge where `mem_req && mem_ready`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- Reset: state IDLE; `sp_q`, `pair_q`, `data_q` = 0; all outputs 0.
- Outputs are decoded from state and internal registers only. No input-to-output combinational path exists.
- All register-file selectors have bit 4 = 1 (pair access).
- In IDLE, all outputs are 0. `start` high latches `op` and `pair_sel`, then moves to LD_SP.
- LD_SP: `rf_read_sel` = SP selector; `sp_q` <= `rf_rdata`. Next state is LD_PAIR for PUSH, MEM_LO for POP.
- PUSH sequence:
  - LD_PAIR: `rf_read_sel` = {1, pair_sel}; `pair_q` <= `rf_rdata`.
  - MEM_HI: write `pair_q[15:8]` to `sp_q-1`.
  - DEC_HI: `rf_ext_op` = DCR, `rf_write_sel` = SP.
  - MEM_LO: write `pair_q[7:0]` to `sp_q-2`.
  - DEC_LO: DCR on SP.
  - DONE.
- POP sequence:
  - MEM_LO: read `sp_q`; `data_q[7:0]` <= `mem_rdata`.
  - INC_LO: INC on SP.
  - MEM_HI: read `sp_q+1`; `data_q[15:8]` <= `mem_rdata`.
  - INC_HI: INC on SP.
  - WB: `rf_write_en` = 1, `rf_write_sel` = {1, pair_sel}, `rf_wdata` = `data_q`.
  - DONE.
- MEM states hold `mem_req` and all address/data stable until `mem_ready` is sampled high, then advance.
- `rf_ext_op` is non-zero for exactly one cycle per INC/DCR state. `rf_write_en` is never asserted together with a non-zero `rf_ext_op`.
- DONE: `done` = 1, `busy` = 1; next state is IDLE.
- Address arithmetic is 16-bit modulo 2^16 (0x0000 - 1 = 0xFFFF).
- PUSH of the SP pair pushes the pre-operation SP value.
- POP into the SP pair: final SP = popped value, because WB follows the increments.
- `start` outside IDLE is ignored and not queued.
- `rst` in any state returns to IDLE at that edge. SP updates already issued remain; no rollback.

## Timing
- With `mem_ready` tied high: PUSH is 7 cycles from the `start` edge to the `done` cycle; POP is 7 cycles.
- Each cycle of `mem_ready` low adds one cycle.
- `start` may be asserted in the cycle after `done`; the next operation begins back-to-back.
- Register-file read is combinational; `rf_rdata` is sampled at the end of the LD state.

## Configuration
- `STACK_ENGINE_INC2_EN` defined:
  - POP omits INC_LO.
  - INC_HI is replaced by INC2, which issues `rf_ext_op` = 11 on SP once.
  - POP latency is 6 cycles with ready tied high.
- Macro undefined: two single INC cycles as above; `rf_ext_op` never equals 11. PUSH is unaffected in both builds.

## Test plan
- SP=0x2000, pair 0 = 0x1234, PUSH -> mem[0x1FFF]=0x12, mem[0x1FFE]=0x34, SP=0x1FFE, `done` in cycle 7, two DCR pulses.
- mem[0x1FFE]=0x34, mem[0x1FFF]=0x12, SP=0x1FFE, POP into pair 2 -> pair 2 = 0x1234, SP=0x2000. `done` in cycle 7, or cycle 6 with `STACK_ENGINE_INC2_EN` and one INC2 pulse.
- SP=0x0000, PUSH -> writes to 0xFFFF then 0xFFFE, SP=0xFFFE.
- `mem_ready` low for 3 cycles on each access -> outputs stable while stalled; PUSH completes in cycle 13.
- `start` pulsed while `busy` -> ignored; exactly one `done`, with register and memory state of a single operation.
- `rst` asserted in MEM_LO of a PUSH -> IDLE next cycle, all outputs 0, no `done`; SP=0x1FFF after the one completed DCR.

Source files
------------

// File: rtl/stack_engine_if.sv
// Register-file and byte-memory bus bundle for stack_engine.
// master = engine side, slave = register file / memory side.
interface stack_engine_if;
  logic [15:0] rf_rdata;
  logic [4:0]  rf_read_sel;
  logic [4:0]  rf_write_sel;
  logic        rf_write_en;
  logic [15:0] rf_wdata;
  logic [1:0]  rf_ext_op;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    input  rf_rdata, mem_rdata, mem_ready,
    output rf_read_sel, rf_write_sel, rf_write_en, rf_wdata, rf_ext_op,
    output mem_addr, mem_wdata, mem_req, mem_we
  );

  modport slave (
    output rf_rdata, mem_rdata, mem_ready,
    input  rf_read_sel, rf_write_sel, rf_write_en, rf_wdata, rf_ext_op,
    input  mem_addr, mem_wdata, mem_req, mem_we
  );
endinterface

// File: rtl/stack_engine.sv
// PUSH/POP register-pair sequencer between the register file and a ready-handshaked byte bus.
// Define STACK_ENGINE_INC2_EN to fold the two POP increments into a single INC2 step.
module stack_engine #(
  parameter logic [3:0] SP_INDEX = 4'd8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [3:0]     pair_sel,
  output logic           busy,
  output logic           done,
  stack_engine_if.master bus
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LD_SP   = 4'd1;
  localparam logic [3:0] S_LD_PAIR = 4'd2;
  localparam logic [3:0] S_MEM_HI  = 4'd3;
  localparam logic [3:0] S_DEC_HI  = 4'd4;
  localparam logic [3:0] S_MEM_LO  = 4'd5;
  localparam logic [3:0] S_DEC_LO  = 4'd6;
  localparam logic [3:0] S_INC_LO  = 4'd7;
  localparam logic [3:0] S_INC_HI  = 4'd8;
  localparam logic [3:0] S_WB      = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  localparam logic [1:0] EXT_INC  = 2'b01;
  localparam logic [1:0] EXT_DCR  = 2'b10;
  localparam logic       OP_PUSH  = 1'b0;
  localparam logic       OP_POP   = 1'b1;
  localparam logic [4:0] SP_SEL   = {1'b1, SP_INDEX};

`ifdef STACK_ENGINE_INC2_EN
  localparam logic [3:0] S_POP_AFTER_LO = S_MEM_HI;
  localparam logic [1:0] EXT_POP_HI     = 2'b11;
`else
  localparam logic [3:0] S_POP_AFTER_LO = S_INC_LO;
  localparam logic [1:0] EXT_POP_HI     = EXT_INC;
`endif

  logic [3:0]  state_reg, state_next;
  logic        op_reg;
  logic [3:0]  pair_sel_reg;
  logic [15:0] sp_reg, pair_reg, data_reg;
  logic        mem_fire;

  assign mem_fire = bus.mem_req && bus.mem_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_LD_SP;
      S_LD_SP:   state_next = (op_reg == OP_POP) ? S_MEM_LO : S_LD_PAIR;
      S_LD_PAIR: state_next = S_MEM_HI;
      S_MEM_HI:  if (mem_fire) state_next = (op_reg == OP_POP) ? S_INC_HI : S_DEC_HI;
      S_DEC_HI:  state_next = S_MEM_LO;
      S_MEM_LO:  if (mem_fire) state_next = (op_reg == OP_POP) ? S_POP_AFTER_LO : S_DEC_LO;
      S_DEC_LO:  state_next = S_DONE;
      S_INC_LO:  state_next = S_MEM_HI;
      S_INC_HI:  state_next = S_WB;
      S_WB:      state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      op_reg       <= OP_PUSH;
      pair_sel_reg <= '0;
      sp_reg       <= '0;
      pair_reg     <= '0;
      data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        op_reg       <= op;
        pair_sel_reg <= pair_sel;
      end
      if (state_reg == S_LD_SP)   sp_reg   <= bus.rf_rdata;
      if (state_reg == S_LD_PAIR) pair_reg <= bus.rf_rdata;
      if (op_reg == OP_POP && mem_fire) begin
        if (state_reg == S_MEM_LO) data_reg[7:0]  <= bus.mem_rdata;
        if (state_reg == S_MEM_HI) data_reg[15:8] <= bus.mem_rdata;
      end
    end
  end

  // Moore outputs: addresses come from the SP value latched in LD_SP, so they
  // stay put across stalls and across the SP updates issued mid-sequence.
  always_comb begin
    busy             = (state_reg != S_IDLE);
    done             = (state_reg == S_DONE);
    bus.rf_read_sel  = '0;
    bus.rf_write_sel = '0;
    bus.rf_write_en  = 1'b0;
    bus.rf_wdata     = '0;
    bus.rf_ext_op    = '0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    case (state_reg)
      S_LD_SP:   bus.rf_read_sel = SP_SEL;
      S_LD_PAIR: bus.rf_read_sel = {1'b1, pair_sel_reg};
      S_MEM_HI: begin
        bus.mem_req = 1'b1;
        if (op_reg == OP_PUSH) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = sp_reg - 16'd1;
          bus.mem_wdata = pair_reg[15:8];
        end else begin
          bus.mem_addr  = sp_reg + 16'd1;
        end
      end
      S_MEM_LO: begin
        bus.mem_req = 1'b1;
        if (op_reg == OP_PUSH) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = sp_reg - 16'd2;
          bus.mem_wdata = pair_reg[7:0];
        end else begin
          bus.mem_addr  = sp_reg;
        end
      end
      S_DEC_HI, S_DEC_LO: begin
        bus.rf_ext_op    = EXT_DCR;
        bus.rf_write_sel = SP_SEL;
      end
      S_INC_LO: begin
        bus.rf_ext_op    = EXT_INC;
        bus.rf_write_sel = SP_SEL;
      end
      S_INC_HI: begin
        bus.rf_ext_op    = EXT_POP_HI;
        bus.rf_write_sel = SP_SEL;
      end
      S_WB: begin
        bus.rf_write_en  = 1'b1;
        bus.rf_write_sel = {1'b1, pair_sel_reg};
        bus.rf_wdata     = data_reg;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: register-file/memory environment,
// a high-level stack model, and directed plus randomized PUSH/POP scenarios.
`timescale 1ns/1ps
module tb_stack_engine;
  localparam logic [3:0] SP_IDX   = 4'd8;
  localparam logic [4:0] SP_SEL   = {1'b1, SP_IDX};
  localparam int         PUSH_LAT = 7;
`ifdef STACK_ENGINE_INC2_EN
  localparam int POP_LAT = 6;
  localparam int POP_EXT = 1;
`else
  localparam int POP_LAT = 7;
  localparam int POP_EXT = 200;
`endif

  logic       clk = 1'b0;
  logic       rst, start, op, busy, done;
  logic [3:0] pair_sel;

  stack_engine_if bus();

  stack_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .pair_sel(pair_sel),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Environment: register file and byte memory driven by the DUT's bus
  logic [7:0] mem [0:65535];
  logic [7:0] rf  [0:15];
  int wait_cnt = 0;
  int stall_min = 0;
  int stall_max = 0;

  assign bus.mem_ready = (wait_cnt == 0);
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.rf_rdata  = {rf[bus.rf_read_sel[3:0]], rf[bus.rf_read_sel[3:0] + 4'd1]};

  always @(posedge clk) begin
    logic [15:0] v;
    logic [3:0]  ws;
    if (!bus.mem_req) wait_cnt <= int'($urandom_range(stall_max, stall_min));
    else if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
    else begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      wait_cnt <= int'($urandom_range(stall_max, stall_min));
    end
    ws = bus.rf_write_sel[3:0];
    if (bus.rf_write_en) begin
      rf[ws] = bus.rf_wdata[15:8];
      rf[ws + 4'd1] = bus.rf_wdata[7:0];
    end
    if (bus.rf_ext_op == 2'b01 || bus.rf_ext_op == 2'b10 || bus.rf_ext_op == 2'b11) begin
      v = {rf[ws], rf[ws + 4'd1]};
      case (bus.rf_ext_op)
        2'b01:   v = v + 16'd1;
        2'b10:   v = v - 16'd1;
        default: v = v + 16'd2;
      endcase
      rf[ws] = v[15:8];
      rf[ws + 4'd1] = v[7:0];
    end
  end

  // Bus monitor, sampled on the falling edge
  int done_cnt = 0, inc_cnt = 0, dcr_cnt = 0, inc2_cnt = 0;
  int ext_bad_cnt = 0, unstable_cnt = 0, stall_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_snap = '0;

  always @(negedge clk) begin
    logic [25:0] snap;
    if (done === 1'b1) done_cnt++;
    case (bus.rf_ext_op)
      2'b01: inc_cnt++;
      2'b10: dcr_cnt++;
      2'b11: inc2_cnt++;
      default: ;
    endcase
    if (bus.rf_ext_op != 2'b00 && (bus.rf_write_en || bus.rf_write_sel != SP_SEL)) ext_bad_cnt++;
    snap = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    if (prev_stall === 1'b1 && snap !== prev_snap) unstable_cnt++;
    prev_stall = bus.mem_req && !bus.mem_ready && !rst;
    prev_snap  = snap;
    if (prev_stall === 1'b1) stall_cyc++;
  end

  // Reference model: plain stack arithmetic over its own copies of the state
  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_rf  [0:15];

  function automatic logic [15:0] ref_pair(input logic [3:0] p);
    return {ref_rf[p], ref_rf[p + 4'd1]};
  endfunction

  function automatic logic [15:0] env_pair(input logic [3:0] p);
    return {rf[p], rf[p + 4'd1]};
  endfunction

  task automatic ref_set(input logic [3:0] p, input logic [15:0] v);
    ref_rf[p] = v[15:8];
    ref_rf[p + 4'd1] = v[7:0];
  endtask

  task automatic set_pair(input logic [3:0] p, input logic [15:0] v);
    rf[p] = v[15:8];
    rf[p + 4'd1] = v[7:0];
    ref_set(p, v);
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic model_op(input logic o, input logic [3:0] p);
    logic [15:0] sp, v;
    sp = ref_pair(SP_IDX);
    if (!o) begin
      v = ref_pair(p);
      ref_mem[sp - 16'd1] = v[15:8];
      ref_mem[sp - 16'd2] = v[7:0];
      ref_set(SP_IDX, sp - 16'd2);
    end else begin
      v = {ref_mem[sp + 16'd1], ref_mem[sp]};
      ref_set(SP_IDX, sp + 16'd2);
      ref_set(p, v);
    end
  endtask

  // Per-operation results from do_op
  int last_lat, last_inc, last_dcr, last_inc2, last_stall, last_done;

  task automatic do_op(input logic o, input logic [3:0] p);
    int s_inc, s_dcr, s_inc2, s_stall, s_done;
    @(negedge clk);
    s_inc = inc_cnt; s_dcr = dcr_cnt; s_inc2 = inc2_cnt; s_stall = stall_cyc; s_done = done_cnt;
    start = 1'b1; op = o; pair_sel = p;
    last_lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      last_lat++;
    end while (done !== 1'b1 && last_lat < 200);
    #1;
    last_inc = inc_cnt - s_inc; last_dcr = dcr_cnt - s_dcr; last_inc2 = inc2_cnt - s_inc2;
    last_stall = stall_cyc - s_stall; last_done = done_cnt - s_done;
    $display("op=%s pair=%0d sp_now=%h cycles=%0d stalls=%0d", o ? "POP " : "PUSH",
             p, env_pair(SP_IDX), last_lat, last_stall);
  endtask

  task automatic test_reset();
    logic [56:0] outs;
    rst = 1'b1; start = 1'b0; op = 1'b0; pair_sel = '0;
    repeat (3) @(negedge clk);
    outs = {busy, done, bus.rf_read_sel, bus.rf_write_sel, bus.rf_write_en, bus.rf_wdata,
            bus.rf_ext_op, bus.mem_addr, bus.mem_wdata, bus.mem_req, bus.mem_we};
    check_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {busy, done, bus.rf_read_sel, bus.rf_write_sel, bus.rf_write_en, bus.rf_wdata,
            bus.rf_ext_op, bus.mem_addr, bus.mem_wdata, bus.mem_req, bus.mem_we};
    check_cnt++;
    if (outs !== '0) $display("FAIL idle_outputs: got %h expected 0", outs);
    else pass_cnt++;
  endtask

  task automatic test_push_basic();
    set_pair(SP_IDX, 16'h2000);
    set_pair(4'd0, 16'h1234);
    model_op(1'b0, 4'd0);
    do_op(1'b0, 4'd0);
    check_cnt++;
    if (last_lat !== PUSH_LAT) $display("FAIL push_latency: got %0d expected %0d", last_lat, PUSH_LAT);
    else pass_cnt++;
    check_cnt++;
    if ({mem[16'h1FFF], mem[16'h1FFE]} !== 16'h1234)
      $display("FAIL push_mem: got %h expected 1234", {mem[16'h1FFF], mem[16'h1FFE]});
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== 16'h1FFE) $display("FAIL push_sp: got %h expected 1ffe", env_pair(SP_IDX));
    else pass_cnt++;
    check_cnt++;
    if (last_dcr !== 2 || last_inc !== 0 || last_inc2 !== 0)
      $display("FAIL push_ext_pulses: got dcr=%0d inc=%0d inc2=%0d expected dcr=2", last_dcr, last_inc, last_inc2);
    else pass_cnt++;
    check_cnt++;
    if (last_done !== 1) $display("FAIL push_done_count: got %0d expected 1", last_done);
    else pass_cnt++;
  endtask

  task automatic test_pop_basic();
    int got_ext;
    set_mem(16'h1FFE, 8'h34);
    set_mem(16'h1FFF, 8'h12);
    set_pair(SP_IDX, 16'h1FFE);
    set_pair(4'd2, 16'hBEEF);
    model_op(1'b1, 4'd2);
    do_op(1'b1, 4'd2);
    check_cnt++;
    if (env_pair(4'd2) !== 16'h1234) $display("FAIL pop_pair: got %h expected 1234", env_pair(4'd2));
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== 16'h2000) $display("FAIL pop_sp: got %h expected 2000", env_pair(SP_IDX));
    else pass_cnt++;
    check_cnt++;
    if (last_lat !== POP_LAT) $display("FAIL pop_latency: got %0d expected %0d", last_lat, POP_LAT);
    else pass_cnt++;
    got_ext = last_inc * 100 + last_dcr * 10 + last_inc2;
    check_cnt++;
    if (got_ext !== POP_EXT) $display("FAIL pop_ext_pulses: got %0d expected %0d", got_ext, POP_EXT);
    else pass_cnt++;
  endtask

  task automatic test_push_wrap();
    set_pair(SP_IDX, 16'h0000);
    set_pair(4'd4, 16'hA55A);
    model_op(1'b0, 4'd4);
    do_op(1'b0, 4'd4);
    check_cnt++;
    if (mem[16'hFFFF] !== 8'hA5) $display("FAIL wrap_mem_hi: got %h expected a5", mem[16'hFFFF]);
    else pass_cnt++;
    check_cnt++;
    if (mem[16'hFFFE] !== 8'h5A) $display("FAIL wrap_mem_lo: got %h expected 5a", mem[16'hFFFE]);
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== 16'hFFFE) $display("FAIL wrap_sp: got %h expected fffe", env_pair(SP_IDX));
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int u0;
    stall_min = 3; stall_max = 3;
    u0 = unstable_cnt;
    set_pair(SP_IDX, 16'h3000);
    set_pair(4'd12, 16'h9ABC);
    model_op(1'b0, 4'd12);
    do_op(1'b0, 4'd12);
    check_cnt++;
    if (last_lat !== 13) $display("FAIL stall_push_latency: got %0d expected 13", last_lat);
    else pass_cnt++;
    check_cnt++;
    if ({mem[16'h2FFF], mem[16'h2FFE]} !== 16'h9ABC)
      $display("FAIL stall_push_mem: got %h expected 9abc", {mem[16'h2FFF], mem[16'h2FFE]});
    else pass_cnt++;
    model_op(1'b1, 4'd14);
    do_op(1'b1, 4'd14);
    check_cnt++;
    if (last_lat !== POP_LAT + 6) $display("FAIL stall_pop_latency: got %0d expected %0d", last_lat, POP_LAT + 6);
    else pass_cnt++;
    check_cnt++;
    if (env_pair(4'd14) !== 16'h9ABC) $display("FAIL stall_pop_pair: got %h expected 9abc", env_pair(4'd14));
    else pass_cnt++;
    check_cnt++;
    if (unstable_cnt - u0 !== 0) $display("FAIL stall_stable: got %0d changes expected 0", unstable_cnt - u0);
    else pass_cnt++;
    stall_min = 0; stall_max = 0;
  endtask

  task automatic test_start_while_busy();
    int d0;
    set_pair(SP_IDX, 16'h4000);
    set_pair(4'd6, 16'h5678);
    model_op(1'b0, 4'd6);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 1'b0; pair_sel = 4'd6;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 4);
      op = 1'b1; pair_sel = 4'd10;
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL busy_done_count: got %0d expected 1", done_cnt - d0);
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== ref_pair(SP_IDX))
      $display("FAIL busy_sp: got %h expected %h", env_pair(SP_IDX), ref_pair(SP_IDX));
    else pass_cnt++;
    check_cnt++;
    if ({mem[16'h3FFF], mem[16'h3FFE]} !== 16'h5678)
      $display("FAIL busy_mem: got %h expected 5678", {mem[16'h3FFF], mem[16'h3FFE]});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int d0;
    logic [56:0] outs;
    set_pair(SP_IDX, 16'h2000);
    set_pair(4'd0, 16'h1234);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 1'b0; pair_sel = 4'd0;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_cnt++;
    if (!(bus.mem_req && bus.mem_we && bus.mem_addr == 16'h1FFE))
      $display("FAIL rst_mid_in_mem_lo: got req=%b we=%b addr=%h expected 1 1 1ffe", bus.mem_req, bus.mem_we, bus.mem_addr);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    outs = {busy, done, bus.rf_read_sel, bus.rf_write_sel, bus.rf_write_en, bus.rf_wdata,
            bus.rf_ext_op, bus.mem_addr, bus.mem_wdata, bus.mem_req, bus.mem_we};
    check_cnt++;
    if (outs !== '0) $display("FAIL rst_mid_outputs: got %h expected 0", outs);
    else pass_cnt++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt - d0);
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== 16'h1FFF) $display("FAIL rst_mid_sp: got %h expected 1fff", env_pair(SP_IDX));
    else pass_cnt++;
    check_cnt++;
    if (mem[16'h1FFF] !== 8'h12) $display("FAIL rst_mid_mem_hi: got %h expected 12", mem[16'h1FFF]);
    else pass_cnt++;
    // The MEM_LO handshake completed on the reset edge, so that byte landed too
    ref_set(SP_IDX, 16'h1FFF);
    ref_mem[16'h1FFF] = 8'h12;
    ref_mem[16'h1FFE] = 8'h34;
  endtask

  task automatic test_back_to_back();
    set_pair(SP_IDX, 16'h8000);
    set_pair(4'd6, 16'hC0DE);
    set_pair(4'd10, 16'h0000);
    model_op(1'b0, 4'd6);
    do_op(1'b0, 4'd6);
    model_op(1'b1, 4'd10);
    do_op(1'b1, 4'd10);
    check_cnt++;
    if (last_lat !== POP_LAT) $display("FAIL b2b_latency: got %0d expected %0d", last_lat, POP_LAT);
    else pass_cnt++;
    check_cnt++;
    if (env_pair(4'd10) !== 16'hC0DE) $display("FAIL b2b_pair: got %h expected c0de", env_pair(4'd10));
    else pass_cnt++;
    check_cnt++;
    if (env_pair(SP_IDX) !== 16'h8000) $display("FAIL b2b_sp: got %h expected 8000", env_pair(SP_IDX));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic        o, bad;
    logic [3:0]  p;
    logic [15:0] sp_pre, a;
    int          exp_lat, exp_ext, got_ext;
    stall_min = 0; stall_max = 2;
    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom_range(1, 0));
      p = 4'(2 * $urandom_range(7, 0));
      if (n % 10 == 0) set_pair(SP_IDX, 16'($urandom));
      sp_pre = ref_pair(SP_IDX);
      model_op(o, p);
      do_op(o, p);
      exp_lat = (o ? POP_LAT : PUSH_LAT) + last_stall;
      check_cnt++;
      if (last_lat !== exp_lat) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, last_lat, exp_lat);
      else pass_cnt++;
      exp_ext = o ? POP_EXT : 10 * 2;
      got_ext = last_inc * 100 + last_dcr * 10 + last_inc2;
      check_cnt++;
      if (got_ext !== exp_ext) $display("FAIL rnd_ext_pulses[%0d]: got %0d expected %0d", n, got_ext, exp_ext);
      else pass_cnt++;
      check_cnt++;
      if (last_done !== 1) $display("FAIL rnd_done[%0d]: got %0d expected 1", n, last_done);
      else pass_cnt++;
      bad = 1'b0;
      for (int i = 0; i < 16; i++) if (rf[i] !== ref_rf[i]) bad = 1'b1;
      check_cnt++;
      if (bad) $display("FAIL rnd_rf[%0d]: got sp=%h pair%0d=%h expected sp=%h pair%0d=%h", n,
                        env_pair(SP_IDX), p, env_pair(p), ref_pair(SP_IDX), p, ref_pair(p));
      else pass_cnt++;
      bad = 1'b0;
      for (int j = 0; j < 6; j++) begin
        a = sp_pre - 16'd3 + 16'(j);
        if (mem[a] !== ref_mem[a]) bad = 1'b1;
      end
      check_cnt++;
      if (bad) $display("FAIL rnd_mem[%0d]: got %h%h expected %h%h at %h", n, mem[sp_pre - 16'd1],
                        mem[sp_pre - 16'd2], ref_mem[sp_pre - 16'd1], ref_mem[sp_pre - 16'd2], sp_pre);
      else pass_cnt++;
    end
    stall_min = 0; stall_max = 0;
  endtask

  task automatic test_protocol();
    check_cnt++;
    if (ext_bad_cnt !== 0) $display("FAIL ext_op_target: got %0d bad cycles expected 0", ext_bad_cnt);
    else pass_cnt++;
    check_cnt++;
    if (unstable_cnt !== 0) $display("FAIL stall_stability: got %0d changes expected 0", unstable_cnt);
    else pass_cnt++;
`ifndef STACK_ENGINE_INC2_EN
    check_cnt++;
    if (inc2_cnt !== 0) $display("FAIL no_inc2: got %0d expected 0", inc2_cnt);
    else pass_cnt++;
`endif
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      rf[i] = b;
      ref_rf[i] = b;
    end
    test_reset();
    test_push_basic();
    test_pop_basic();
    test_push_wrap();
    test_stall();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
